// File: rtl/upme_pkg.sv
// Shared types and constants for the upme status-bus monitor.
package upme_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [1:0] {
        IDLE,
        TRACK,
        ERROR
    } state_t;

    localparam logic [1:0] ERR_NONE = 2'b00;
    localparam logic [1:0] ERR_SKIP = 2'b01;
    localparam logic [1:0] ERR_DIR  = 2'b10;

endpackage

// File: rtl/upme_step_cls.sv
// Classifies one sampled-to-current state transition of the upme bus.
// Purely combinational; exactly one of hold/step_up/step_dn/bad_dir/bad_skip is high.
module upme_step_cls
    import upme_pkg::*;
(
    input  logic [STATE_W-1:0] pst,
    input  logic               pdir,
    input  logic [STATE_W-1:0] cur,
    output logic               step_up,
    output logic               step_dn,
    output logic               hold,
    output logic               bad_skip,
    output logic               bad_dir,
    output logic               wrap
);

    logic [STATE_W-1:0] delta;
    logic               fwd;
    logic               bwd;

    // Unsigned subtraction wraps naturally, giving the modulo-8 distance.
    assign delta = cur - pst;
    assign fwd   = (delta == STATE_W'(1));
    assign bwd   = (delta == '1);

    assign hold     = (delta == '0);
    assign step_up  = fwd &&  pdir;
    assign step_dn  = bwd && !pdir;
    assign bad_dir  = (fwd && !pdir) || (bwd && pdir);
    assign bad_skip = !hold && !fwd && !bwd;
    assign wrap     = (step_up && (pst == '1)) || (step_dn && (pst == '0));

endmodule

// File: rtl/upme_monitor.sv
// Checks that the upme state walks one step per enable in the commanded direction;
// tracks signed position, wrap counts, a sticky first error and a stall watchdog.
module upme_monitor
    import upme_pkg::*;
#(
    parameter int POS_W   = 8,
    parameter int WRAP_W  = 4,
    parameter int TIMEOUT = 64
) (
    input  logic              eck,
    input  logic              er,
    input  logic [3:0]        iea,
    input  logic              clr,
    output logic [POS_W-1:0]  pos,
    output logic [WRAP_W-1:0] wraps_up,
    output logic [WRAP_W-1:0] wraps_dn,
    output logic              err,
    output logic [1:0]        err_code,
    output logic              stall,
    output logic              tracking
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    state_t             state;
    state_t             state_nxt;
    logic [STATE_W-1:0] pst;
    logic               pdir;
    logic [CNT_W-1:0]   idle_cnt;
    logic [CNT_W-1:0]   idle_cnt_inc;

    logic step_up;
    logic step_dn;
    logic hold;
    logic bad_skip;
    logic bad_dir;
    logic wrap;

    upme_step_cls u_cls (
        .pst      (pst),
        .pdir     (pdir),
        .cur      (iea[STATE_W-1:0]),
        .step_up  (step_up),
        .step_dn  (step_dn),
        .hold     (hold),
        .bad_skip (bad_skip),
        .bad_dir  (bad_dir),
        .wrap     (wrap)
    );

    // The sample register runs unconditionally so IDLE only has to wait one edge.
    always_ff @(posedge eck or posedge er) begin
        if (er) begin
            pst  <= '0;
            pdir <= 1'b0;
        end else begin
            pst  <= iea[STATE_W-1:0];
            pdir <= iea[3];
        end
    end

    always_ff @(posedge eck or posedge er) begin
        if (er) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = TRACK;
            TRACK:   if (bad_skip || bad_dir) state_nxt = ERROR;
            ERROR:   state_nxt = ERROR;
            default: state_nxt = IDLE;
        endcase
        if (clr) begin
            state_nxt = IDLE;
        end
    end

    assign idle_cnt_inc = (idle_cnt == CNT_W'(TIMEOUT)) ? idle_cnt : idle_cnt + CNT_W'(1);

    always_ff @(posedge eck or posedge er) begin
        if (er) begin
            pos      <= '0;
            wraps_up <= '0;
            wraps_dn <= '0;
            err_code <= ERR_NONE;
            idle_cnt <= '0;
            stall    <= 1'b0;
        end else if (clr) begin
            pos      <= '0;
            wraps_up <= '0;
            wraps_dn <= '0;
            err_code <= ERR_NONE;
            idle_cnt <= '0;
            stall    <= 1'b0;
        end else if (state == TRACK) begin
            if (hold) begin
                idle_cnt <= idle_cnt_inc;
                stall    <= (idle_cnt_inc == CNT_W'(TIMEOUT));
            end
            if (step_up) begin
                pos      <= pos + POS_W'(1);
                idle_cnt <= '0;
                stall    <= 1'b0;
                if (wrap && (wraps_up != '1)) begin
                    wraps_up <= wraps_up + WRAP_W'(1);
                end
            end
            if (step_dn) begin
                pos      <= pos - POS_W'(1);
                idle_cnt <= '0;
                stall    <= 1'b0;
                if (wrap && (wraps_dn != '1)) begin
                    wraps_dn <= wraps_dn + WRAP_W'(1);
                end
            end
            // Direction mismatch takes precedence in code only because the two are exclusive.
            if (bad_dir) begin
                err_code <= ERR_DIR;
            end else if (bad_skip) begin
                err_code <= ERR_SKIP;
            end
        end
    end

    assign err      = (state == ERROR);
    assign tracking = (state == TRACK);

endmodule

// File: tb/tb_upme_monitor.sv
// Directed stimulus for upme_monitor, checked every cycle against an integer-level model.
module tb_upme_monitor;

    localparam int TO = 64;

    logic       eck = 1'b0;
    logic       er  = 1'b1;
    logic [3:0] iea = 4'b0000;
    logic       clr = 1'b0;
    logic [7:0] pos;
    logic [3:0] wraps_up;
    logic [3:0] wraps_dn;
    logic       err;
    logic [1:0] err_code;
    logic       stall;
    logic       tracking;

    int total = 0;
    int bad   = 0;

    upme_monitor #(.POS_W(8), .WRAP_W(4), .TIMEOUT(TO)) dut (
        .eck      (eck),
        .er       (er),
        .iea      (iea),
        .clr      (clr),
        .pos      (pos),
        .wraps_up (wraps_up),
        .wraps_dn (wraps_dn),
        .err      (err),
        .err_code (err_code),
        .stall    (stall),
        .tracking (tracking)
    );

    always #5 eck = ~eck;

    // Model: mode 0 = waiting for first sample, 1 = tracking, 2 = latched error.
    int m_mode  = 0;
    int m_pos   = 0;
    int m_wu    = 0;
    int m_wd    = 0;
    int m_cnt   = 0;
    int m_stall = 0;
    int m_code  = 0;
    int m_pst   = 0;
    int m_pdir  = 0;

    function void m_clear();
        m_mode  = 0;
        m_pos   = 0;
        m_wu    = 0;
        m_wd    = 0;
        m_cnt   = 0;
        m_stall = 0;
        m_code  = 0;
    endfunction

    always @(posedge eck or posedge er) begin
        int cur;
        int dir;
        int delta;
        if (er) begin
            m_clear();
            m_pst  = 0;
            m_pdir = 0;
        end else begin
            cur = int'(iea[2:0]);
            dir = int'(iea[3]);
            if (clr) begin
                m_clear();
            end else if (m_mode == 0) begin
                m_mode = 1;
            end else if (m_mode == 1) begin
                delta = (cur - m_pst + 8) % 8;
                if (delta == 0) begin
                    if (m_cnt < TO) m_cnt = m_cnt + 1;
                    if (m_cnt == TO) m_stall = 1;
                end else if (delta == 1 && m_pdir == 1) begin
                    m_pos = m_pos + 1;
                    if (m_pst == 7 && m_wu < 15) m_wu = m_wu + 1;
                    m_cnt   = 0;
                    m_stall = 0;
                end else if (delta == 7 && m_pdir == 0) begin
                    m_pos = m_pos - 1;
                    if (m_pst == 0 && m_wd < 15) m_wd = m_wd + 1;
                    m_cnt   = 0;
                    m_stall = 0;
                end else begin
                    m_code = (delta == 1 || delta == 7) ? 2 : 1;
                    m_mode = 2;
                end
            end
            m_pst  = cur;
            m_pdir = dir;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("FAIL %s got=%0h want=%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    always @(negedge eck) begin
        chk("m_pos",      {24'b0, pos},         32'(((m_pos % 256) + 256) % 256));
        chk("m_wraps_up", {28'b0, wraps_up},    32'(m_wu));
        chk("m_wraps_dn", {28'b0, wraps_dn},    32'(m_wd));
        chk("m_err",      {31'b0, err},         32'(m_mode == 2));
        chk("m_err_code", {30'b0, err_code},    32'(m_code));
        chk("m_stall",    {31'b0, stall},       32'(m_stall));
        chk("m_tracking", {31'b0, tracking},    32'(m_mode == 1));
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge eck);
    endtask

    initial begin
        // Reset
        cyc(1);
        chk("rst_pos",      {24'b0, pos}, 32'h0);
        chk("rst_tracking", {31'b0, tracking}, 32'h0);
        chk("rst_err",      {31'b0, err}, 32'h0);
        chk("rst_stall",    {31'b0, stall}, 32'h0);
        er  = 1'b0;
        iea = 4'b1000;
        cyc(3);

        // Full up walk with one wrap
        for (int s = 1; s <= 8; s++) begin
            iea = {1'b1, 3'(s % 8)};
            cyc(4);
        end
        chk("up_pos",   {24'b0, pos}, 32'd8);
        chk("up_wraps", {28'b0, wraps_up}, 32'd1);
        chk("up_err",   {31'b0, err}, 32'd0);

        // Down walk through the 0->7 boundary
        clr = 1'b1; iea = 4'b0000; cyc(1);
        clr = 1'b0; cyc(3);
        iea = 4'b0111; cyc(4);
        iea = 4'b0110; cyc(4);
        chk("dn_pos",      {24'b0, pos}, 32'hFE);
        chk("dn_wraps",    {28'b0, wraps_dn}, 32'd1);
        chk("dn_tracking", {31'b0, tracking}, 32'd1);

        // Skip error freezes everything
        clr = 1'b1; iea = 4'b1000; cyc(1);
        clr = 1'b0; cyc(2);
        iea = 4'b1001; cyc(2);
        iea = 4'b1010; cyc(2);
        iea = 4'b1101; cyc(1);
        chk("skip_err",  {31'b0, err}, 32'd1);
        chk("skip_code", {30'b0, err_code}, 32'd1);
        chk("skip_pos",  {24'b0, pos}, 32'd2);
        iea = 4'b1110; cyc(2);
        iea = 4'b1111; cyc(2);
        chk("skip_frozen", {24'b0, pos}, 32'd2);
        chk("skip_code2",  {30'b0, err_code}, 32'd1);

        // Direction mismatch, then clear
        clr = 1'b1; iea = 4'b0011; cyc(1);
        clr = 1'b0; cyc(2);
        iea = 4'b0100; cyc(1);
        chk("dir_code", {30'b0, err_code}, 32'd2);
        chk("dir_err",  {31'b0, err}, 32'd1);
        clr = 1'b1; cyc(1);
        clr = 1'b0;
        chk("clr_err",      {31'b0, err}, 32'd0);
        chk("clr_code",     {30'b0, err_code}, 32'd0);
        chk("clr_tracking", {31'b0, tracking}, 32'd0);
        cyc(1);
        chk("clr_track1", {31'b0, tracking}, 32'd1);

        // Stall watchdog
        clr = 1'b1; iea = 4'b1100; cyc(1);
        clr = 1'b0; cyc(1);
        cyc(TO - 1);
        chk("stall_pre", {31'b0, stall}, 32'd0);
        cyc(1);
        chk("stall_on", {31'b0, stall}, 32'd1);
        iea = 4'b1101; cyc(1);
        chk("stall_off", {31'b0, stall}, 32'd0);
        chk("stall_pos", {24'b0, pos}, 32'd1);

        // Async reset mid-sequence
        clr = 1'b1; iea = 4'b1000; cyc(1);
        clr = 1'b0; cyc(2);
        for (int s = 1; s <= 3; s++) begin
            iea = {1'b1, 3'(s)};
            cyc(2);
        end
        chk("er_pre_pos", {24'b0, pos}, 32'd3);
        @(posedge eck);
        #2 er = 1'b1;
        #1;
        chk("er_async_pos",      {24'b0, pos}, 32'd0);
        chk("er_async_tracking", {31'b0, tracking}, 32'd0);
        @(negedge eck);
        er = 1'b0; iea = 4'b1110;
        cyc(3);

        // clr coincident with a skip wins
        iea = 4'b1011; clr = 1'b1; cyc(1);
        clr = 1'b0;
        chk("clr_skip_err", {31'b0, err}, 32'd0);
        cyc(3);
        chk("clr_skip_err2",  {31'b0, err}, 32'd0);
        chk("clr_skip_track", {31'b0, tracking}, 32'd1);

        @(posedge eck);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
